// File: rtl/ps2_rx_event_fifo_if.sv
// Key-event handshake between ps2_rx_event_fifo (master) and its consumer (slave).
// With PS2_ASCII_EN defined the bundle also carries the ASCII translation of the head event.
interface ps2_rx_event_fifo_if #(
  parameter int FIFO_DEPTH = 8
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic             ev_valid;
  logic             ev_ready;
  logic [7:0]       ev_code;
  logic             ev_release;
  logic             ev_extended;
  logic [CNT_W-1:0] ev_count;
`ifdef PS2_ASCII_EN
  logic [7:0]       ev_ascii;

  modport master (output ev_valid, ev_code, ev_release, ev_extended, ev_count, ev_ascii,
                  input  ev_ready);
  modport slave  (input  ev_valid, ev_code, ev_release, ev_extended, ev_count, ev_ascii,
                  output ev_ready);
`else
  modport master (output ev_valid, ev_code, ev_release, ev_extended, ev_count,
                  input  ev_ready);
  modport slave  (input  ev_valid, ev_code, ev_release, ev_extended, ev_count,
                  output ev_ready);
`endif
endinterface

// File: rtl/ps2_rx_event_fifo.sv
// PS/2 keyboard receiver with glitch filter, frame checking, receive timeout,
// E0/F0 prefix decoding and a show-ahead event FIFO.
// Optional feature macro: PS2_ASCII_EN (adds ev_ascii, head-entry set-2 to ASCII lookup).
module ps2_rx_event_fifo #(
  parameter int SAMPLE_DIV    = 250,
  parameter int FILTER_LEN    = 4,
  parameter int TIMEOUT_TICKS = 4000,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ps2_clk,
  input  logic                      ps2_data,
  ps2_rx_event_fifo_if.master       ev,
  output logic                      frame_err,
  output logic                      overflow,
  input  logic                      ovf_clr
);
  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int FLT_W = $clog2(FILTER_LEN);
  localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, GOT_E0 = 2'd1, GOT_F0 = 2'd2, GOT_E0F0 = 2'd3} dec_state_e;

  // Odd parity holds when the data byte and parity bit together have an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  // Frame layout LSB first: [0] start, [8:1] data, [9] parity, [10] stop.
  function automatic logic frame_ok(input logic [10:0] f);
    return (f[0] == 1'b0) && (f[10] == 1'b1) && odd_parity_ok(f[8:1], f[9]);
  endfunction

  logic [1:0]       clk_sync_r, data_sync_r;
  logic [DIV_W-1:0] div_r;
  logic             tick_r;
  logic             filt_r, fall_r, fall_data_r;
  logic [FLT_W-1:0] run_r;
  logic [10:0]      sh_r;
  logic [3:0]       bit_cnt_r;
  logic [TO_W-1:0]  to_cnt_r;
  logic             byte_vld_r, byte_bad_r, frame_err_r;
  logic [7:0]       byte_r;
  dec_state_e       state_r;
  logic             push_r, push_rel_r, push_ext_r;
  logic [7:0]       push_code_r;
  logic [9:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             valid_r, overflow_r;
  logic [9:0]       head_r;

  logic             full_s, pop_s, wr_en_s, drop_s;
  logic [CNT_W-1:0] count_nxt_s, remain_s;
  logic [PTR_W-1:0] rd_ptr_nxt_s;
  logic [9:0]       push_entry_s, head_nxt_s;

  // Two-flop synchronisers; idle-high reset value so no edge is seen out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_r  <= 2'b11;
      data_sync_r <= 2'b11;
    end else begin
      clk_sync_r  <= {clk_sync_r[0], ps2_clk};
      data_sync_r <= {data_sync_r[0], ps2_data};
    end
  end

  // Sample-tick divider: one-clk tick each time the divider wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_r  <= '0;
      tick_r <= 1'b0;
    end else if (div_r == DIV_W'(SAMPLE_DIV - 1)) begin
      div_r  <= '0;
      tick_r <= 1'b1;
    end else begin
      div_r  <= div_r + DIV_W'(1);
      tick_r <= 1'b0;
    end
  end

  // Glitch filter: flip the filtered clock after FILTER_LEN consecutive opposite samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_r      <= 1'b1;
      run_r       <= '0;
      fall_r      <= 1'b0;
      fall_data_r <= 1'b0;
    end else begin
      fall_r <= 1'b0;
      if (tick_r) begin
        if (clk_sync_r[1] == filt_r) begin
          run_r <= '0;
        end else if (run_r == FLT_W'(FILTER_LEN - 1)) begin
          filt_r      <= ~filt_r;
          run_r       <= '0;
          fall_r      <= filt_r;
          fall_data_r <= data_sync_r[1];
        end else begin
          run_r <= run_r + FLT_W'(1);
        end
      end
    end
  end

  // Bit collection, frame check on the clk after the 11th bit, and partial-frame timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_r        <= '0;
      bit_cnt_r   <= 4'd0;
      to_cnt_r    <= '0;
      byte_r      <= 8'h00;
      byte_vld_r  <= 1'b0;
      byte_bad_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      byte_vld_r  <= 1'b0;
      byte_bad_r  <= 1'b0;
      frame_err_r <= 1'b0;
      if (bit_cnt_r == 4'd11) begin
        bit_cnt_r <= 4'd0;
        to_cnt_r  <= '0;
        byte_r    <= sh_r[8:1];
        if (frame_ok(sh_r)) begin
          byte_vld_r <= 1'b1;
        end else begin
          byte_bad_r  <= 1'b1;
          frame_err_r <= 1'b1;
        end
      end else if (fall_r) begin
        sh_r      <= {fall_data_r, sh_r[10:1]};
        bit_cnt_r <= bit_cnt_r + 4'd1;
        to_cnt_r  <= '0;
      end else if (tick_r && (bit_cnt_r != 4'd0)) begin
        if (to_cnt_r == TO_W'(TIMEOUT_TICKS - 1)) begin
          bit_cnt_r   <= 4'd0;
          to_cnt_r    <= '0;
          frame_err_r <= 1'b1;
        end else begin
          to_cnt_r <= to_cnt_r + TO_W'(1);
        end
      end
    end
  end

  // Prefix decoder: E0/F0 bytes only move the state, other bytes push a flagged event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      push_r      <= 1'b0;
      push_code_r <= 8'h00;
      push_rel_r  <= 1'b0;
      push_ext_r  <= 1'b0;
    end else begin
      push_r <= 1'b0;
      if (byte_bad_r) begin
        state_r <= IDLE;
      end else if (byte_vld_r) begin
        if (byte_r == 8'hE0) begin
          state_r <= GOT_E0;
        end else if (byte_r == 8'hF0) begin
          case (state_r)
            IDLE, GOT_F0:     state_r <= GOT_F0;
            GOT_E0, GOT_E0F0: state_r <= GOT_E0F0;
            default:          state_r <= IDLE;
          endcase
        end else begin
          push_r      <= 1'b1;
          push_code_r <= byte_r;
          push_rel_r  <= (state_r == GOT_F0) || (state_r == GOT_E0F0);
          push_ext_r  <= (state_r == GOT_E0) || (state_r == GOT_E0F0);
          state_r     <= IDLE;
        end
      end
    end
  end

  assign push_entry_s = {push_code_r, push_rel_r, push_ext_r};

  // FIFO next-state; head is looked ahead so the registered outputs track the pop exactly.
  always_comb begin
    full_s       = (count_r == CNT_W'(FIFO_DEPTH));
    pop_s        = valid_r && ev.ev_ready;
    wr_en_s      = push_r && (!full_s || pop_s);
    drop_s       = push_r && full_s && !pop_s;
    count_nxt_s  = count_r + CNT_W'(wr_en_s) - CNT_W'(pop_s);
    remain_s     = count_r - CNT_W'(pop_s);
    rd_ptr_nxt_s = pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
    head_nxt_s   = 10'd0;
    if (count_nxt_s == '0) begin
      head_nxt_s = 10'd0;
    end else if (remain_s == '0) begin
      head_nxt_s = push_entry_s;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // FIFO storage, pointers, registered head/valid/count and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 10'd0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      valid_r    <= 1'b0;
      head_r     <= 10'd0;
      overflow_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= push_entry_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      valid_r  <= (count_nxt_s != '0);
      head_r   <= head_nxt_s;
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (ovf_clr) begin
        overflow_r <= 1'b0;
      end
    end
  end

  assign ev.ev_valid    = valid_r;
  assign ev.ev_code     = head_r[9:2];
  assign ev.ev_release  = head_r[1];
  assign ev.ev_extended = head_r[0];
  assign ev.ev_count    = count_r;
  assign frame_err      = frame_err_r;
  assign overflow       = overflow_r;

`ifdef PS2_ASCII_EN
  // Set-2 letter and digit codes to uppercase ASCII; everything else maps to 00.
  function automatic logic [7:0] set2_ascii(input logic [7:0] c);
    case (c)
      8'h1C: return 8'h41; 8'h32: return 8'h42; 8'h21: return 8'h43; 8'h23: return 8'h44;
      8'h24: return 8'h45; 8'h2B: return 8'h46; 8'h34: return 8'h47; 8'h33: return 8'h48;
      8'h43: return 8'h49; 8'h3B: return 8'h4A; 8'h42: return 8'h4B; 8'h4B: return 8'h4C;
      8'h3A: return 8'h4D; 8'h31: return 8'h4E; 8'h44: return 8'h4F; 8'h4D: return 8'h50;
      8'h15: return 8'h51; 8'h2D: return 8'h52; 8'h1B: return 8'h53; 8'h2C: return 8'h54;
      8'h3C: return 8'h55; 8'h2A: return 8'h56; 8'h1D: return 8'h57; 8'h22: return 8'h58;
      8'h35: return 8'h59; 8'h1A: return 8'h5A;
      8'h45: return 8'h30; 8'h16: return 8'h31; 8'h1E: return 8'h32; 8'h26: return 8'h33;
      8'h25: return 8'h34; 8'h2E: return 8'h35; 8'h36: return 8'h36; 8'h3D: return 8'h37;
      8'h3E: return 8'h38; 8'h46: return 8'h39;
      default: return 8'h00;
    endcase
  endfunction

  assign ev.ev_ascii = (valid_r && !head_r[0]) ? set2_ascii(head_r[9:2]) : 8'h00;
`endif
endmodule

// File: tb/tb_ps2_rx_event_fifo.sv
// Self-checking bench for ps2_rx_event_fifo: directed and random frames against a
// queue-based event model.
module tb_ps2_rx_event_fifo;
  localparam int SAMPLE_DIV    = 4;
  localparam int FILTER_LEN    = 2;
  localparam int TIMEOUT_TICKS = 50;
  localparam int FIFO_DEPTH    = 4;
  localparam int HP            = 40;

  logic clk = 1'b0;
  logic rst, ps2_clk, ps2_data, ovf_clr;
  logic frame_err, overflow;

  ps2_rx_event_fifo_if #(.FIFO_DEPTH(FIFO_DEPTH)) ev_if ();

  ps2_rx_event_fifo #(
    .SAMPLE_DIV(SAMPLE_DIV), .FILTER_LEN(FILTER_LEN),
    .TIMEOUT_TICKS(TIMEOUT_TICKS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .ev(ev_if),
    .frame_err(frame_err), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [7:0] code; logic rel; logic ext;} ev_t;

  int  checks = 0, errors = 0;
  ev_t exp_q[$];
  bit  m_e0 = 0, m_f0 = 0, exp_ovf = 0;
  int  exp_err = 0, err_high = 0, valid_cycles = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_ascii(input ev_t e);
    logic [7:0] letters [26];
    logic [7:0] digits [10];
    letters = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,8'h42,8'h4B,8'h3A,
                8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    digits  = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
    if (e.ext) return 8'h00;
    for (int i = 0; i < 26; i++) if (letters[i] == e.code) return 8'(8'h41 + i);
    for (int i = 0; i < 10; i++) if (digits[i] == e.code) return 8'(8'h30 + i);
    return 8'h00;
  endfunction

  // Keyboard-level meaning of one received byte: prefixes set flags, other bytes are events.
  task automatic model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      exp_err++; m_e0 = 0; m_f0 = 0;
    end else if (b == 8'hE0) begin
      m_e0 = 1; m_f0 = 0;
    end else if (b == 8'hF0) begin
      m_f0 = 1;
    end else begin
      if (exp_q.size() >= FIFO_DEPTH) exp_ovf = 1;
      else exp_q.push_back('{code: b, rel: m_f0, ext: m_e0});
      m_e0 = 0; m_f0 = 0;
    end
  endtask

  // Consumer side: every accepted event must be the oldest expected one.
  always @(negedge clk) begin
    if (frame_err === 1'b1) err_high++;
    if (ev_if.ev_valid === 1'b1) valid_cycles++;
    if (ev_if.ev_valid === 1'b1 && ev_if.ev_ready === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL pop_unexpected observed=%0h expected=none", ev_if.ev_code);
      end
      if (exp_q.size() > 0) begin
        check("ev_code", ev_if.ev_code, exp_q[0].code);
        check("ev_release", ev_if.ev_release, exp_q[0].rel);
        check("ev_extended", ev_if.ev_extended, exp_q[0].ext);
`ifdef PS2_ASCII_EN
        check("ev_ascii", ev_if.ev_ascii, model_ascii(exp_q[0]));
`endif
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int nbits, input int glitch_bit);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      repeat (HP) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10) model_byte(b, !bad_par && !bad_stop);
      repeat (HP) @(negedge clk);
      ps2_clk = 1'b1;
      if (i == glitch_bit) begin
        repeat (HP / 2) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
      end
    end
    ps2_data = 1'b1;
    repeat (HP) @(negedge clk);
  endtask

  task automatic settle(input string tag);
    repeat (100) @(negedge clk);
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_frame_err"}, err_high, exp_err);
  endtask

  initial begin
    int v0, waited;
    logic [7:0] b;
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; ovf_clr = 1'b0; ev_if.ev_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", ev_if.ev_valid, 0);
    check("rst_code", ev_if.ev_code, 0);
    check("rst_count", ev_if.ev_count, 0);
    check("rst_flags", {ev_if.ev_release, ev_if.ev_extended}, 0);
    check("rst_overflow", overflow, 0);
    check("rst_frame_err", frame_err, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Plain make code, consumer always ready: one event held for exactly one clk.
    ev_if.ev_ready = 1'b1;
    v0 = valid_cycles;
    send_frame(8'h1C, 0, 0, 11, -1);
    settle("t1");
    check("t1_valid_cycles", valid_cycles - v0, 1);

    // Extended break and extended make; prefixes alone produce nothing.
    v0 = valid_cycles;
    send_frame(8'hE0, 0, 0, 11, -1);
    send_frame(8'hF0, 0, 0, 11, -1);
    send_frame(8'h75, 0, 0, 11, -1);
    send_frame(8'hE0, 0, 0, 11, -1);
    send_frame(8'h6B, 0, 0, 11, -1);
    settle("t2");
    check("t2_valid_cycles", valid_cycles - v0, 2);

    // Bad parity, then bad stop on a prefix, then a clean make.
    send_frame(8'h1C, 1, 0, 11, -1);
    send_frame(8'hF0, 0, 1, 11, -1);
    send_frame(8'h1C, 0, 0, 11, -1);
    settle("t3");

    // Partial frame must time out; next frame is received normally.
    send_frame(8'h55, 0, 0, 5, -1);
    exp_err++;
    repeat (TIMEOUT_TICKS * SAMPLE_DIV + 100) @(negedge clk);
    check("t4_timeout_err", err_high, exp_err);
    send_frame(8'h15, 0, 0, 11, -1);
    settle("t4");

    // Fill with the consumer stalled, then drain and clear the sticky overflow.
    ev_if.ev_ready = 1'b0;
    send_frame(8'h16, 0, 0, 11, -1);
    send_frame(8'h1E, 0, 0, 11, -1);
    send_frame(8'h26, 0, 0, 11, -1);
    send_frame(8'h25, 0, 0, 11, -1);
    send_frame(8'h2E, 0, 0, 11, -1);
    repeat (60) @(negedge clk);
    check("t5_count", ev_if.ev_count, FIFO_DEPTH);
    check("t5_overflow", overflow, exp_ovf);
    check("t5_head", ev_if.ev_code, exp_q[0].code);
    ev_if.ev_ready = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("t5_drain_done", exp_q.size(), 0);
    repeat (5) @(negedge clk);
    check("t5_empty_valid", ev_if.ev_valid, 0);
    check("t5_empty_code", ev_if.ev_code, 0);
    check("t5_ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    exp_ovf = 0;
    check("t5_ovf_cleared", overflow, 0);
    settle("t5");

    // Short glitch on the keyboard clock must not add a bit.
    send_frame(8'h2C, 0, 0, 11, 4);
    settle("t6");

    // Random byte stream with occasional corruption and stalls.
    for (int n = 0; n < 14; n++) begin
      case ($urandom_range(0, 5))
        0: b = 8'hE0;
        1: b = 8'hF0;
        default: b = 8'($urandom_range(1, 127));
      endcase
      ev_if.ev_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) send_frame(b, $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0 ? 0 : 1, 11, -1);
      else send_frame(b, 0, 0, 11, -1);
    end
    ev_if.ev_ready = 1'b1;
    settle("t7");
    check("t7_overflow", overflow, exp_ovf);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    exp_ovf = 0;
    m_e0 = 0; m_f0 = 0;
    send_frame(8'h33, 0, 0, 11, -1);
    settle("t7b");

    // Asynchronous reset in the middle of a frame while an event is held.
    ev_if.ev_ready = 1'b0;
    send_frame(8'h24, 0, 0, 11, -1);
    repeat (40) @(negedge clk);
    check("t8_held_valid", ev_if.ev_valid, 1);
    send_frame(8'h4D, 0, 0, 6, -1);
    #2 rst = 1'b1;
    #1;
    check("t8_rst_valid", ev_if.ev_valid, 0);
    check("t8_rst_code", ev_if.ev_code, 0);
    check("t8_rst_count", ev_if.ev_count, 0);
    exp_q.delete();
    m_e0 = 0; m_f0 = 0; exp_ovf = 0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    ev_if.ev_ready = 1'b1;
    repeat (HP) @(negedge clk);
    send_frame(8'h1D, 0, 0, 11, -1);
    settle("t8");
    check("t8_overflow", overflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
